// File: rtl/alu_pkg.sv
// Shared ALU datapath types: op encoding, adder status flags,
// and the segment-width helper for the pipelined adder.
package alu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } add_flags_t;

  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/add_segment.sv
// Combinational W-bit ripple-carry segment built from full_adder cells.
module add_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[W];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined add/sub: one ripple segment per stage, operands skewed
// forward with the beat, global-stall valid/ready handshake.
module pipe_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG_W = seg_w(WIDTH, STAGES);

  if ((WIDTH % STAGES) != 0 || WIDTH < 2) begin : g_bad_cfg
    $error("pipe_add_sub: WIDTH must be >= 2 and divisible by STAGES");
  end

  op_e op;
  logic adv;
  logic [WIDTH-1:0] b_eff;
  logic c0;

  assign op    = op_e'(sub);
  assign adv   = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c0    = (op == OP_SUB) ? ~cin : cin;

  // Bank k holds the beat that stage k works on this cycle
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];

  logic [STAGES-1:0][SEG_W-1:0] seg_s;
  logic [STAGES-1:0]            seg_c;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_segment #(.W(SEG_W)) u_seg (
      .a  (a_q[k][k*SEG_W +: SEG_W]),
      .b  (b_q[k][k*SEG_W +: SEG_W]),
      .ci (c_q[k]),
      .s  (seg_s[k]),
      .co (seg_c[k])
    );
  end

  logic [WIDTH-1:0] fsum;
  add_flags_t       flags;

  always_comb begin
    fsum = s_q[STAGES-1];
    fsum[WIDTH-1 -: SEG_W] = seg_s[STAGES-1];
    flags.cout = seg_c[STAGES-1];
    flags.ovf  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
              && (fsum[WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
    flags.zero = (fsum == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= 1'b0;
        s_q[k] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      a_q[0] <= a;
      b_q[0] <= b_eff;
      c_q[0] <= c0;
      s_q[0] <= '0;
      for (int k = 0; k < STAGES - 1; k++) begin
        v_q[k+1] <= v_q[k];
        a_q[k+1] <= a_q[k];
        b_q[k+1] <= b_q[k];
        c_q[k+1] <= seg_c[k];
        s_q[k+1] <= s_q[k];
        s_q[k+1][k*SEG_W +: SEG_W] <= seg_s[k];
      end
      out_valid <= v_q[STAGES-1];
      sum       <= fsum;
      cout      <= flags.cout;
      ovf       <= flags.ovf;
      zero      <= flags.zero;
    end
  end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Directed and random checks for pipe_add_sub (WIDTH=16, STAGES=4).
module tb_pipe_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [18:0] q [$];

  always #5 clk = ~clk;

  pipe_add_sub #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {cout, ovf, zero, sum}
  function automatic logic [18:0] model(input logic [15:0] x,
      input logic [15:0] y, input logic ci, input logic s);
    logic [15:0] ye;
    logic        c0;
    logic [16:0] r;
    logic        v;
    ye = s ? ~y : y;
    c0 = s ? ~ci : ci;
    r  = {1'b0, x} + {1'b0, ye} + {16'd0, c0};
    v  = (x[15] == ye[15]) && (r[15] != x[15]);
    return {r[16], v, (r[15:0] == 16'd0), r[15:0]};
  endfunction

  task automatic tick();
    logic fin;
    logic fout;
    logic [18:0] e;
    #1;
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready;
    if (fout) begin
      pops++;
      chk("q_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("result", {13'd0, cout, ovf, zero, sum}, {13'd0, e});
      end
    end
    @(posedge clk);
    if (!rst_n) q.delete();
    else if (fin) q.push_back(model(a, b, cin, sub));
    #1;
  endtask

  task automatic run1(input string tag, input logic [15:0] x,
      input logic [15:0] y, input logic ci, input logic s,
      input logic [15:0] es, input logic ec, input logic eo,
      input logic ez);
    int lat;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_flags"}, {29'd0, cout, ovf, zero}, {29'd0, ec, eo, ez});
    tick();
  endtask

  initial begin
    int sent;
    int p0;
    int seen;
    logic [15:0] hold;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run1("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1, 0, 1);
    run1("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 0, 1, 0);
    run1("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1, 1, 0);
    run1("borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 0, 0, 0);
    run1("borrow_c", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 0, 0, 0);
    run1("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 0, 0, 0);

    // Backpressure: stall in cycles 6..8 after the first accept
    sent = 0; p0 = pops; hold = '0;
    for (int i = 0; i < 20; i++) begin
      out_ready = !(i >= 6 && i <= 8);
      in_valid  = (sent < 8);
      a   = 16'h1111 * 16'(sent + 1);
      b   = 16'h0F0F + 16'(sent);
      cin = sent[0];
      sub = sent[1];
      #1;
      if (i <= 10)
        chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready),
            32'(!(i >= 6 && i <= 8)));
      if (i == 6) hold = sum;
      if (i == 7 || i == 8) chk("bp_stable", 32'(sum), 32'(hold));
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_count", 32'(pops - p0), 32'd8);

    // Reset with three beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0100 + 16'(i); b = 16'h0002; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("mid_rst_stale", 32'(seen), 32'd0);
    run1("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 0, 0, 0);

    // Random sweep with random handshakes
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
